// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART defines: bus address, default sizing and transmitter state encoding.
package uart_tx_buffer_pkg;

  // Memory-mapped address the CPU stores to in order to queue a byte.
  localparam logic [31:0] UART_ADDR = 32'h1000_0000;

  // Default sizing; both are overridable per instance.
  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DEFAULT_DEPTH        = 16;

  // Payload bits per 8N1 frame.
  localparam int DATA_BITS = 8;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO feeding the UART transmitter: storage, wrapping pointers,
// registered level/full/empty flags and a sticky overflow flag.
module uart_byte_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [AW:0]   level_next;
  logic          full_reg;
  logic          empty_reg;
  logic          overflow_reg;
  logic          push;
  logic          pop;

  // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push = wr_en && !full_reg;
  assign pop  = rd_en && !empty_reg;

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Byte storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers, flags and the sticky overflow; reset takes priority over writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg    <= level_next;
      full_reg     <= (level_next == LEVEL_FULL);
      empty_reg    <= (level_next == '0);
      overflow_reg <= overflow_reg | (wr_en && full_reg);
    end
  end

  // Head of queue is presented directly so the transmitter can load it on the pop edge.
  assign rd_data  = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: CPU byte writes go into a FIFO, and the
// FSM shifts them out LSB first with back-to-back frames when data is waiting.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int DEPTH        = DEFAULT_DEPTH,
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          busy,
  output logic          uart_tx
);

  localparam int          BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t     state_reg;
  tx_state_t     state_next;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          uart_tx_reg;
  logic          tx_bit_next;
  logic          fifo_pop;
  logic [7:0]    fifo_rd_data;
  logic          baud_last;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (fifo_pop),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign baud_last = (baud_reg == BAUD_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= TX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the registered empty flag guarantees a fresh push is seen one cycle late.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TX_IDLE:  if (!empty) state_next = TX_START;
      TX_START: if (baud_last) state_next = TX_DATA;
      TX_DATA:  if (baud_last && (bit_reg == LAST_BIT)) state_next = TX_STOP;
      TX_STOP:  if (baud_last) state_next = empty ? TX_IDLE : TX_START;
      default:  state_next = TX_IDLE;
    endcase
  end

  // FSM outputs: when to pop the FIFO and what level the line should take next.
  always_comb begin
    fifo_pop    = 1'b0;
    tx_bit_next = 1'b1;
    case (state_reg)
      TX_IDLE:  fifo_pop = !empty;
      TX_START: tx_bit_next = 1'b0;
      TX_DATA:  tx_bit_next = shift_reg[0];
      TX_STOP:  fifo_pop = baud_last && !empty;
      default:  tx_bit_next = 1'b1;
    endcase
  end

  // Baud counter, bit counter, shift register and the registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      uart_tx_reg <= 1'b1;
    end else begin
      uart_tx_reg <= tx_bit_next;
      if (fifo_pop) begin
        shift_reg <= fifo_rd_data;
        bit_reg   <= '0;
        baud_reg  <= '0;
      end else if (state_reg != TX_IDLE) begin
        if (baud_last) begin
          baud_reg <= '0;
          if (state_reg == TX_DATA) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_reg   <= bit_reg + 1'b1;
          end
        end else begin
          baud_reg <= baud_reg + 1'b1;
        end
      end
    end
  end

  assign uart_tx = uart_tx_reg;
  assign busy    = (state_reg != TX_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer (CLKS_PER_BIT=4, DEPTH=4): a reset/fill
// vector table, hand-written corner sequences and randomized traffic, all
// compared every cycle against a frame-position reference model.
module tb_uart_tx_buffer;

  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       overflow;
  logic       busy;
  logic       uart_tx;

  uart_tx_buffer #(
    .CLKS_PER_BIT (C),
    .DEPTH        (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queued bytes, byte on the wire and its cycle position in the frame (-1 = idle).
  logic [7:0] mq[$];
  int         m_pos = -1;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_tx  = 1'b1;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] data;
    int         level;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       tx;
    logic       busy;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Advance the model across one rising edge.
  task automatic model_edge(input logic r, input logic w, input logic [7:0] d);
    int  pre_pos;
    bit  pre_empty;
    bit  pre_full;
    if (r) begin
      mq.delete();
      m_pos = -1;
      m_ovf = 1'b0;
      m_tx  = 1'b1;
      return;
    end
    pre_empty = (mq.size() == 0);
    pre_full  = (mq.size() == D);
    pre_pos   = m_pos;
    m_tx      = (pre_pos >= 0) ? frame_bit(m_cur, pre_pos / C) : 1'b1;
    if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == FRAME) m_pos = -1;
    end
    if ((pre_pos == -1 || pre_pos == FRAME - 1) && !pre_empty) begin
      m_cur = mq.pop_front();
      m_pos = 0;
    end
    if (w) begin
      if (!pre_full) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  // Drive one cycle, advance the model, then compare every output against it.
  task automatic step(input logic r, input logic w, input logic [7:0] d);
    rst     = r;
    wr_en   = w;
    wr_data = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
    chk("model uart_tx",  32'(uart_tx),  32'(m_tx));
    chk("model level",    32'(level),    32'(mq.size()));
    chk("model full",     32'(full),     32'(mq.size() == D));
    chk("model empty",    32'(empty),    32'(mq.size() == 0));
    chk("model overflow", 32'(overflow), 32'(m_ovf));
    chk("model busy",     32'(busy),     32'((m_pos >= 0) || (mq.size() > 0)));
  endtask

  task automatic wait_pos(input int target, input string name);
    for (int t = 0; t < 400 && m_pos != target; t++) step(1'b0, 1'b0, 8'h00);
    if (m_pos != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: frame position %0d never reached, at %0d", name, target, m_pos);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat55;
    int         lows;

    // Six writes from IDLE: first byte popped, FIFO fills, sixth write dropped.
    tbl[0] = '{1'b1, 1'b1, 8'h99, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h10, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'h12, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'h13, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h14, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'h15, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].data);
      chk("vec level",    32'(level),    32'(tbl[i].level));
      chk("vec full",     32'(full),     32'(tbl[i].full));
      chk("vec empty",    32'(empty),    32'(tbl[i].empty));
      chk("vec overflow", 32'(overflow), 32'(tbl[i].ovf));
      chk("vec uart_tx",  32'(uart_tx),  32'(tbl[i].tx));
      chk("vec busy",     32'(busy),     32'(tbl[i].busy));
      $display("vec %0d: rst=%0b wr=%0b data=%02h -> level=%0d full=%0b empty=%0b ovf=%0b tx=%0b busy=%0b",
               i, tbl[i].rst, tbl[i].wr, tbl[i].data, level, full, empty, overflow, uart_tx, busy);
    end
    // Let the five accepted bytes drain; overflow must stay sticky throughout.
    for (int i = 0; i < 5 * FRAME + 10; i++) step(1'b0, 1'b0, 8'h00);
    chk("drain overflow sticky", 32'(overflow), 32'd1);
    chk("drain busy", 32'(busy), 32'd0);
    $display("seq overflow-drop: drained, overflow=%0b busy=%0b", overflow, busy);

    // Single 0x55 frame, checked against its literal line pattern.
    pat55 = 10'b1010101010;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 44; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (i == 0 || i > 40) chk("0x55 idle line", 32'(uart_tx), 32'd1);
      else chk("0x55 frame bit", 32'(uart_tx), 32'(pat55[(i-1)/4]));
      if (i == 39) chk("0x55 busy in stop", 32'(busy), 32'd1);
      if (i == 40) chk("0x55 busy after stop", 32'(busy), 32'd0);
    end
    $display("seq single 0x55: done");

    // Five writes fill the FIFO; a write on the pop edge is still dropped.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i));
    chk("five writes full", 32'(full), 32'd1);
    chk("five writes no overflow", 32'(overflow), 32'd0);
    wait_pos(FRAME - 1, "pop-edge wait");
    step(1'b0, 1'b1, 8'hEE);
    chk("write on pop edge level", 32'(level), 32'd3);
    chk("write on pop edge overflow", 32'(overflow), 32'd1);
    chk("write on pop edge full", 32'(full), 32'd0);
    for (int i = 0; i < 4 * FRAME + 10; i++) step(1'b0, 1'b0, 8'h00);
    chk("five frames drained", 32'(empty), 32'd1);
    $display("seq full+pop write: level=%0d overflow=%0b", level, overflow);

    // Reset during data bit 3 of 0xA5 with two bytes queued.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    chk("abort queued level", 32'(level), 32'd2);
    wait_pos(C * 4 + 1, "bit-3 wait");
    step(1'b1, 1'b0, 8'h00);
    chk("abort uart_tx", 32'(uart_tx), 32'd1);
    chk("abort level", 32'(level), 32'd0);
    chk("abort empty", 32'(empty), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("abort no further frames", 32'(lows), 32'd0);
    $display("seq reset mid-frame: line low cycles after reset=%0d", lows);

    // Write landing on the last stop cycle with the FIFO empty: one idle cycle gap.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h3C);
    wait_pos(FRAME - 1, "last-stop wait");
    step(1'b0, 1'b1, 8'hFF);
    chk("late write level", 32'(level), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("late write gap line", 32'(uart_tx), 32'd1);
    chk("late write popped", 32'(level), 32'd0);
    step(1'b0, 1'b0, 8'h00);
    chk("late write start bit", 32'(uart_tx), 32'd0);
    $display("seq write on last stop cycle: done");

    // Randomized traffic with bursts and occasional resets.
    begin
      int burst = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic r;
        logic w;
        if (burst == 0 && $urandom_range(0, 99) == 0) burst = 40;
        r = ($urandom_range(0, 699) == 0);
        w = (burst > 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 3);
        if (burst > 0) burst--;
        step(r, w, 8'($urandom));
      end
    end
    $display("seq random: 3000 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
